// File: rtl/stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: stall bus width,
// per-stage hold vectors and FSM state encodings.
package stall_ctrl_pkg;

  localparam int STALL_W = 6;
  localparam int STAT_W  = 32;

  typedef logic [STALL_W-1:0] stall_bus_t;

  // bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
  localparam stall_bus_t STALL_NONE = 6'b000000;
  localparam stall_bus_t STALL_ID   = 6'b000111;
  localparam stall_bus_t STALL_EX   = 6'b001111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EX_BUSY = 2'd1,
    ST_FLUSH   = 2'd2
  } state_e;

endpackage

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller.
// Arbitrates ID load-use hazards, multi-cycle EX operations and flush
// requests into per-stage hold bits and a one-cycle flush pulse.
// Optional feature: define STALL_CTRL_STATS_EN to count cycles in which
// the ID stage is held (stall_cycles); otherwise stall_cycles is tied to 0.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_id,
  input  logic               ex_mc_start,
  input  logic [CNT_W-1:0]   ex_mc_cycles,
  input  logic               flush_req,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic               ex_busy,
  output logic [STAT_W-1:0]  stall_cycles
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  stall_bus_t       stall_c;
  logic             flush_c;

  // State and remaining-cycle counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and stall/flush decode; flush_req overrides everything
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = STALL_NONE;
    flush_c = 1'b0;
    if (flush_req) begin
      flush_c = 1'b1;
      state_d = ST_FLUSH;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ex_mc_start && (ex_mc_cycles != '0)) begin
            // The start cycle itself is the first of the K stall cycles.
            stall_c = STALL_EX;
            if (ex_mc_cycles > CNT_W'(1)) begin
              cnt_d   = ex_mc_cycles - CNT_W'(1);
              state_d = ST_EX_BUSY;
            end
          end else if (stallreq_id) begin
            stall_c = STALL_ID;
          end
        end
        ST_EX_BUSY: begin
          stall_c = STALL_EX;
          cnt_d   = cnt_q - CNT_W'(1);
          // cnt_q==0 cannot occur here; treat it as done for robustness.
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_FLUSH: begin
          stall_c = STALL_ID;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are forced quiet while reset is held, whatever the inputs do
  assign stall   = rst ? stall_c : STALL_NONE;
  assign flush   = rst & flush_c;
  assign ex_busy = (state_q == ST_EX_BUSY);

`ifdef STALL_CTRL_STATS_EN
  logic [STAT_W-1:0] stat_q;

  // Saturating count of cycles in which the ID stage is held
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stat_q <= '0;
    else if (stall[2] && (stat_q != '1))
      stat_q <= stat_q + STAT_W'(1);
  end

  assign stall_cycles = stat_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: directed scenarios plus a randomized
// run against a cycle-level behavioural model of remaining stall work.
module tb_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_id = 1'b0;
  logic        ex_mc_start = 1'b0;
  logic [5:0]  ex_mc_cycles = '0;
  logic        flush_req = 1'b0;
  logic [5:0]  stall;
  logic        flush;
  logic        ex_busy;
  logic [31:0] stall_cycles;

`ifdef STALL_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  // model: remaining busy cycles after the start cycle, flush-recovery flag
  int          rem = 0;
  bit          inf = 0;
  longint      stat_m = 0;
  logic [5:0]  e_stall;
  logic        e_flush, e_busy;
  logic [31:0] e_stat;
  logic [5:0]  o_stall;
  logic        o_flush, o_busy;
  logic [31:0] o_stat;

  stall_ctrl #(.CNT_W(6)) dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_mc_start(ex_mc_start),
    .ex_mc_cycles(ex_mc_cycles), .flush_req(flush_req), .stall(stall),
    .flush(flush), .ex_busy(ex_busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // One clock cycle: apply inputs, sample at negedge, advance model at posedge
  task automatic cyc(input logic sr, input logic st, input logic [5:0] k, input logic fr);
    stallreq_id = sr; ex_mc_start = st; ex_mc_cycles = k; flush_req = fr;
    @(negedge clk);
    o_stall = stall; o_flush = flush; o_busy = ex_busy; o_stat = stall_cycles;
    e_flush = fr;
    e_busy  = (rem > 0);
    e_stat  = STATS ? 32'(stat_m) : 32'd0;
    if (fr)                  e_stall = 6'b000000;
    else if (inf)            e_stall = 6'b000111;
    else if (rem > 0)        e_stall = 6'b001111;
    else if (st && k != 0)   e_stall = 6'b001111;
    else if (sr)             e_stall = 6'b000111;
    else                     e_stall = 6'b000000;
    @(posedge clk);
    if (e_stall[2]) stat_m++;
    if (fr)                begin rem = 0; inf = 1; end
    else if (inf)          inf = 0;
    else if (rem > 0)      rem--;
    else if (st && k != 0) rem = int'(k) - 1;
    #1;
  endtask

  task automatic model_reset();
    rem = 0; inf = 0; stat_m = 0;
  endtask

  task automatic test_reset();
    stallreq_id = 1; ex_mc_start = 1; ex_mc_cycles = 6'd5; flush_req = 1;
    #2;
    tests++;
    if (stall !== 6'b0 || flush !== 1'b0 || ex_busy !== 1'b0 || stall_cycles !== 32'd0) begin
      fails++;
      $display("FAIL reset_outputs: stall=%b flush=%b busy=%b cnt=%0d, want all zero",
               stall, flush, ex_busy, stall_cycles);
    end
    @(negedge clk);
    stallreq_id = 0; ex_mc_start = 0; ex_mc_cycles = 0; flush_req = 0;
    rst = 1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_id_stall();
    cyc(1, 0, 0, 0);
    tests++;
    if (o_stall !== 6'b000111 || o_flush !== 1'b0) begin
      fails++; $display("FAIL id_stall: stall=%b flush=%b, want 000111/0", o_stall, o_flush);
    end
    cyc(0, 0, 0, 0);
    tests++;
    if (o_stall !== 6'b000000) begin
      fails++; $display("FAIL id_stall_release: stall=%b, want 000000", o_stall);
    end
  endtask

  task automatic test_multicycle();
    int n_st = 0, n_busy = 0;
    cyc(0, 1, 6'd5, 0);
    if (o_stall === 6'b001111) n_st++;
    if (o_busy) n_busy++;
    // random ID requests and extra starts while busy must be ignored
    for (int i = 0; i < 4; i++) begin
      cyc(1'($urandom_range(0, 1)), 1, 6'd7, 0);
      if (o_stall === 6'b001111) n_st++;
      if (o_busy) n_busy++;
    end
    cyc(0, 0, 0, 0);
    tests++;
    if (n_st != 5) begin fails++; $display("FAIL mc5_stall_cycles: got %0d, want 5", n_st); end
    tests++;
    if (n_busy != 4) begin fails++; $display("FAIL mc5_busy_cycles: got %0d, want 4", n_busy); end
    tests++;
    if (o_stall !== 6'b0 || o_busy !== 1'b0) begin
      fails++; $display("FAIL mc5_after: stall=%b busy=%b, want 0/0", o_stall, o_busy);
    end
  endtask

  task automatic test_k1_k0();
    cyc(0, 1, 6'd1, 0);
    tests++;
    if (o_stall !== 6'b001111 || o_busy !== 1'b0) begin
      fails++; $display("FAIL k1_start: stall=%b busy=%b, want 001111/0", o_stall, o_busy);
    end
    cyc(0, 0, 0, 0);
    tests++;
    if (o_stall !== 6'b0 || o_busy !== 1'b0) begin
      fails++; $display("FAIL k1_after: stall=%b busy=%b, want 0/0", o_stall, o_busy);
    end
    cyc(0, 1, 6'd0, 0);
    tests++;
    if (o_stall !== 6'b0 || o_busy !== 1'b0) begin
      fails++; $display("FAIL k0_start: stall=%b busy=%b, want 0/0", o_stall, o_busy);
    end
    cyc(0, 0, 0, 0);
    tests++;
    if (o_busy !== 1'b0 || o_stall !== 6'b0) begin
      fails++; $display("FAIL k0_after: stall=%b busy=%b, want 0/0", o_stall, o_busy);
    end
  endtask

  task automatic test_flush();
    cyc(0, 1, 6'd10, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    tests++;
    if (o_flush !== 1'b1 || o_stall !== 6'b0) begin
      fails++; $display("FAIL flush_cycle: flush=%b stall=%b, want 1/000000", o_flush, o_stall);
    end
    cyc(1, 1, 6'd4, 0);
    tests++;
    if (o_stall !== 6'b000111 || o_flush !== 1'b0 || o_busy !== 1'b0) begin
      fails++; $display("FAIL flush_recover: stall=%b flush=%b busy=%b, want 000111/0/0",
                        o_stall, o_flush, o_busy);
    end
    cyc(0, 0, 0, 0);
    tests++;
    if (o_stall !== 6'b0 || o_busy !== 1'b0 || o_flush !== 1'b0) begin
      fails++; $display("FAIL flush_idle: stall=%b busy=%b flush=%b, want 0/0/0",
                        o_stall, o_busy, o_flush);
    end
  endtask

  task automatic do_async_reset();
    #2;
    rst = 0; flush_req = 1; stallreq_id = 1; ex_mc_start = 1;
    #1;
    tests++;
    if (stall !== 6'b0 || flush !== 1'b0 || ex_busy !== 1'b0 || stall_cycles !== 32'd0) begin
      fails++; $display("FAIL async_reset: stall=%b flush=%b busy=%b cnt=%0d, want zeros",
                        stall, flush, ex_busy, stall_cycles);
    end
    @(posedge clk);
    @(negedge clk);
    stallreq_id = 0; ex_mc_start = 0; ex_mc_cycles = 0; flush_req = 0;
    rst = 1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    cyc(0, 1, 6'd10, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    do_async_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 0);
      tests++;
      if (o_stall !== 6'b0 || o_busy !== 1'b0) begin
        fails++; $display("FAIL post_reset_%0d: stall=%b busy=%b, want 0/0", i, o_stall, o_busy);
      end
    end
  endtask

  task automatic test_stats();
    logic [31:0] want;
    do_async_reset();
    cyc(0, 1, 6'd5, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    want = STATS ? 32'd7 : 32'd0;
    tests++;
    if (o_stat !== want) begin
      fails++; $display("FAIL stats_count: stall_cycles=%0d, want %0d", o_stat, want);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
          6'($urandom_range(0, 12)), 1'($urandom_range(0, 19) == 0));
      tests++;
      if (o_stall !== e_stall || o_flush !== e_flush || o_busy !== e_busy || o_stat !== e_stat) begin
        fails++;
        $display("FAIL random_%0d: stall=%b flush=%b busy=%b cnt=%0d, want %b/%b/%b/%0d",
                 i, o_stall, o_flush, o_busy, o_stat, e_stall, e_flush, e_busy, e_stat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_id_stall();
    test_multicycle();
    test_k1_k0();
    test_flush();
    test_async_reset();
    test_stats();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
